pulse_param_sync: RTL and testbench
===================================

Name: pulse_param_sync

Overview:
- Consumer-side stage downstream of the SPI command decoder.
- Runs in the pulse-generator clock domain (100 MHz).
- Takes the decoder's stretched ack pulses and the quasi-static *_data_async words, synchronises them, range-checks them, and commits the active machining parameters at safe pulse-period boundaries.
- In the other direction, it periodically publishes a 32-bit status/feedback word with its own stretched ack, which the decoder returns to the host.

Parameters:
- TON_DEFAULT, 80: reset/active value of ton.
- TOFF_DEFAULT, 20: reset/active value of toff.
- IP_DEFAULT, 30: reset/active value of ip.
- TON_MIN / TON_MAX, 1 / 1000: legal ton range.
- TOFF_MIN / TOFF_MAX, 1 / 1000: legal toff range.
- IP_MIN / IP_MAX, 1 / 100: legal ip range.
- WAVEFORM_NUM, 4: waveform codes 0..WAVEFORM_NUM-1 are legal.
- FEEDBACK_PERIOD, 1000: clk cycles between feedback publications. Must be ≥ ACK_HOLD+8.
- ACK_HOLD, 4: cycles change_feedback_ack is held high.

Ports:
- clk  in  1: 100 MHz pulse-domain clock.
- rst_n  in  1: async active-low reset.
- machine_start_ack  in  1: stretched start pulse, async.
- machine_stop_ack  in  1: stretched stop pulse, async.
- Ton_data_async, Toff_data_async, Ip_data_async, waveform_data_async  in  16 each: parameter words, stable while and after the matching ack.
- change_Ton_ack, change_Toff_ack, change_Ip_ack, change_waveform_ack  in  1 each: stretched update pulses, async.
- period_boundary  in  1: 1-cycle pulse from the pulse generator at the end of each Ton+Toff period.
- machine_on  out  1: run enable.
- ton_active, toff_active, ip_active, waveform_active  out  16 each: committed parameters.
- param_update  out  1: 1-cycle pulse when any pending parameter commits.
- feedback_data_async  out  32: status word.
- change_feedback_ack  out  1: stretched feedback-valid pulse.

Behaviour:
- Reset values:
  - machine_on = 0.
  - Active registers = TON_DEFAULT / TOFF_DEFAULT / IP_DEFAULT / 0.
  - Shadows equal their actives; pending flags = 0; error flags = 0.
  - param_update = 0; feedback_data_async = 0; change_feedback_ack = 0.
  - Feedback timer = 0; pulse counter = 0.
- Synchronisation:
  - Each of the 6 ack inputs passes through a 3-FF synchroniser.
  - An event is the rising edge on the synchroniser output (stage2 & ~stage3), giving exactly one event per ack regardless of its width.
  - Latency from input rise to event is 3–4 clk.
- Parameter capture (on ton, toff or ip event):
  - Sample the async word into the shadow register and set pending.
  - If value < MIN, store MIN and set the sticky err flag.
  - If value > MAX, store MAX and set the sticky err flag.
- Waveform capture (on waveform event):
  - A code ≥ WAVEFORM_NUM is discarded: shadow and pending are unchanged, and wave_err is set.
- Events on different parameters in the same cycle are all captured.
- A second event on the same parameter before commit overwrites the shadow; pending stays 1.
- Commit:
  - When machine_on=0, any pending shadows copy to active on the cycle after capture.
  - When machine_on=1, copy only on a period_boundary cycle.
  - All pending parameters commit atomically in the same cycle, then clear their pending flags.
  - param_update pulses in that same cycle.
  - If a capture and a commit coincide on the same parameter, the newly captured value is the one committed.
- Start/stop:
  - A start event sets machine_on in the next cycle, clears all err flags and zeroes the pulse counter.
  - Pending parameters commit in the same cycle as the start event, before the machine runs.
  - A stop event clears machine_on.
  - If start and stop events occur in the same cycle, stop wins.
  - A start while already on only clears errors and the counter.
- Pulse counter:
  - 24-bit; increments on period_boundary while machine_on=1.
  - Saturates at 0xFFFFFF.
- Feedback:
  - The timer counts 0..FEEDBACK_PERIOD-1 and wraps.
  - At wrap, latch feedback_data_async as:
    - [31] machine_on
    - [30] ton_err, [29] toff_err, [28] ip_err, [27] wave_err
    - [26:24] 0
    - [23:0] pulse counter
  - In the same cycle, assert change_feedback_ack for exactly ACK_HOLD cycles.
  - feedback_data_async is stable from the latch until the next wrap.
- Reset mid-operation: everything returns to reset values immediately. There is no partial commit.

Test Plan:
- Reset → machine_on=0; ton/toff/ip/waveform_active = 80/20/30/0; first change_feedback_ack high at cycle 1000 for 4 cycles with data 0x00000000.
- Machine off; Ton_data_async=150 with a 9-cycle-wide change_Ton_ack → ton_active=150 within 5 clk; exactly one param_update pulse.
- Start; then Toff=50 and Ip=40 updates; period_boundary 200 cycles later → toff/ip stay 20/30 until that boundary, then both change in the same cycle with one param_update.
- Ton=0, Toff=2000, Ip=500, waveform=7 → ton=1, toff=1000, ip=100 (after commit); waveform_active unchanged; feedback[30:27]=4'b1111. A subsequent start clears the bits to 0.
- machine_start_ack and machine_stop_ack rising in the same cycle → machine_on stays 0; start with 5 period_boundary pulses → feedback[23:0]=5, [31]=1.
- Assert rst_n=0 while a Ton update is pending and the machine is running → all outputs at reset values; ton_active=80; no param_update after release.

Source files
------------

// File: rtl/pulse_param_sync_if.sv
// pulse_param_sync_if
// Decoder-facing bundle between the SPI command decoder (master) and the
// pulse-domain parameter stage (slave).
//   machine_start_ack / machine_stop_ack : stretched start/stop pulses
//   *_data_async                         : quasi-static parameter words
//   change_*_ack                         : stretched parameter-update pulses
//   feedback_data_async                  : 32-bit status word back to decoder
//   change_feedback_ack                  : stretched feedback-valid pulse
interface pulse_param_sync_if;
   logic        machine_start_ack;
   logic        machine_stop_ack;
   logic [15:0] Ton_data_async;
   logic [15:0] Toff_data_async;
   logic [15:0] Ip_data_async;
   logic [15:0] waveform_data_async;
   logic        change_Ton_ack;
   logic        change_Toff_ack;
   logic        change_Ip_ack;
   logic        change_waveform_ack;
   logic [31:0] feedback_data_async;
   logic        change_feedback_ack;

   modport master (
      output machine_start_ack, machine_stop_ack,
      output Ton_data_async, Toff_data_async, Ip_data_async, waveform_data_async,
      output change_Ton_ack, change_Toff_ack, change_Ip_ack, change_waveform_ack,
      input  feedback_data_async, change_feedback_ack
   );

   modport slave (
      input  machine_start_ack, machine_stop_ack,
      input  Ton_data_async, Toff_data_async, Ip_data_async, waveform_data_async,
      input  change_Ton_ack, change_Toff_ack, change_Ip_ack, change_waveform_ack,
      output feedback_data_async, change_feedback_ack
   );
endinterface

// File: rtl/pulse_param_sync.sv
// pulse_param_sync
// Pulse-domain consumer of the SPI decoder. Synchronises the decoder's
// stretched acks, range-checks the parameter words into shadow registers and
// commits them to the active set at safe points (immediately while stopped,
// on period_boundary while running). Periodically publishes a status word.
// Ports:
//   clk, rst_n      : pulse-domain clock, async active-low reset
//   dec             : decoder bundle (slave side)
//   period_boundary : 1-cycle pulse at the end of each Ton+Toff period
//   machine_on      : run enable
//   *_active        : committed ton / toff / ip / waveform
//   param_update    : 1-cycle pulse when pending parameters commit
module pulse_param_sync #(
   parameter int TON_DEFAULT     = 80,
   parameter int TOFF_DEFAULT    = 20,
   parameter int IP_DEFAULT      = 30,
   parameter int TON_MIN         = 1,
   parameter int TON_MAX         = 1000,
   parameter int TOFF_MIN        = 1,
   parameter int TOFF_MAX        = 1000,
   parameter int IP_MIN          = 1,
   parameter int IP_MAX          = 100,
   parameter int WAVEFORM_NUM    = 4,
   parameter int FEEDBACK_PERIOD = 1000,
   parameter int ACK_HOLD        = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   pulse_param_sync_if.slave   dec,
   input  logic                period_boundary,
   output logic                machine_on,
   output logic [15:0]         ton_active,
   output logic [15:0]         toff_active,
   output logic [15:0]         ip_active,
   output logic [15:0]         waveform_active,
   output logic                param_update
);

   localparam int TMR_W  = $clog2(FEEDBACK_PERIOD);
   localparam int HOLD_W = $clog2(ACK_HOLD + 1);
   localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(FEEDBACK_PERIOD - 1);
   localparam logic [HOLD_W-1:0] HOLD_RLD = HOLD_W'(ACK_HOLD - 1);
   localparam logic [23:0]       CNT_MAX  = 24'hFF_FFFF;

   // Bit positions in the synchroniser / event vectors.
   localparam int TON   = 0;
   localparam int TOFF  = 1;
   localparam int IP    = 2;
   localparam int WAVE  = 3;
   localparam int START = 4;
   localparam int STOP  = 5;

   localparam logic [3:0][15:0] PARAM_RST = {16'h0000, 16'(IP_DEFAULT),
                                             16'(TOFF_DEFAULT), 16'(TON_DEFAULT)};

   // Returns {out_of_range, clamped_value}.
   function automatic logic [16:0] clamp_word(input logic [15:0] v,
                                              input logic [15:0] lo,
                                              input logic [15:0] hi);
      logic [16:0] r;
      if (v < lo) begin
         r = {1'b1, lo};
      end else if (v > hi) begin
         r = {1'b1, hi};
      end else begin
         r = {1'b0, v};
      end
      return r;
   endfunction

   logic [5:0]       ack_s;
   logic [5:0]       sync1_q, sync1_d;
   logic [5:0]       sync2_q, sync2_d;
   logic [5:0]       sync3_q, sync3_d;
   logic [5:0]       evt_s;

   logic [3:0][15:0] word_s;
   logic [3:0][15:0] cap_val_s;
   logic [3:0]       cap_err_s;
   logic [3:0]       cap_s;

   logic [3:0][15:0] shadow_q, shadow_d;
   logic [3:0][15:0] active_q, active_d;
   logic [3:0]       pending_q, pending_d;
   logic [3:0]       err_q, err_d;
   logic             commit_s;
   logic             param_update_q, param_update_d;

   logic             start_eff_s;
   logic             machine_on_q, machine_on_d;
   logic [23:0]      pulse_cnt_q, pulse_cnt_d;

   logic [TMR_W-1:0]  timer_q, timer_d;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic              wrap_s;
   logic              fb_ack_q, fb_ack_d;
   logic [31:0]       fb_data_q, fb_data_d;

   assign ack_s  = {dec.machine_stop_ack, dec.machine_start_ack,
                    dec.change_waveform_ack, dec.change_Ip_ack,
                    dec.change_Toff_ack, dec.change_Ton_ack};
   assign word_s = {dec.waveform_data_async, dec.Ip_data_async,
                    dec.Toff_data_async, dec.Ton_data_async};

   // Three-stage synchroniser chain and rising-edge event detection.
   always_comb begin
      sync1_d = ack_s;
      sync2_d = sync1_q;
      sync3_d = sync2_q;
      evt_s   = sync2_q & ~sync3_q;
   end

   // Range check of the incoming words; an illegal waveform code is dropped.
   always_comb begin
      cap_val_s = shadow_q;
      cap_err_s = 4'b0000;
      {cap_err_s[TON],  cap_val_s[TON]}  = clamp_word(word_s[TON],  16'(TON_MIN),  16'(TON_MAX));
      {cap_err_s[TOFF], cap_val_s[TOFF]} = clamp_word(word_s[TOFF], 16'(TOFF_MIN), 16'(TOFF_MAX));
      {cap_err_s[IP],   cap_val_s[IP]}   = clamp_word(word_s[IP],   16'(IP_MIN),   16'(IP_MAX));
      if (word_s[WAVE] < 16'(WAVEFORM_NUM)) begin
         cap_val_s[WAVE] = word_s[WAVE];
         cap_err_s[WAVE] = 1'b0;
      end else begin
         cap_val_s[WAVE] = shadow_q[WAVE];
         cap_err_s[WAVE] = 1'b1;
      end
      cap_s = {evt_s[WAVE] & ~cap_err_s[WAVE], evt_s[IP], evt_s[TOFF], evt_s[TON]};
   end

   // Run state, error flags and pulse counter.
   always_comb begin
      // A start coinciding with a stop is ignored entirely.
      start_eff_s  = evt_s[START] & ~evt_s[STOP];
      machine_on_d = machine_on_q;
      pulse_cnt_d  = pulse_cnt_q;
      err_d        = err_q;

      if (evt_s[STOP]) begin
         machine_on_d = 1'b0;
      end else if (start_eff_s) begin
         machine_on_d = 1'b1;
      end else begin
         machine_on_d = machine_on_q;
      end

      if (start_eff_s) begin
         pulse_cnt_d = 24'h00_0000;
      end else if (machine_on_q && period_boundary && (pulse_cnt_q != CNT_MAX)) begin
         pulse_cnt_d = pulse_cnt_q + 24'h00_0001;
      end else begin
         pulse_cnt_d = pulse_cnt_q;
      end

      if (start_eff_s) begin
         err_d = 4'b0000;
      end else begin
         err_d = err_q;
      end
      // A capture error in the same cycle as a start still sets its flag.
      err_d = err_d | (evt_s[3:0] & cap_err_s);
   end

   // Shadow capture and atomic commit of all pending parameters.
   always_comb begin
      shadow_d       = shadow_q;
      pending_d      = pending_q;
      active_d       = active_q;
      param_update_d = 1'b0;

      for (int i = 0; i < 4; i++) begin
         if (cap_s[i]) begin
            shadow_d[i]  = cap_val_s[i];
            pending_d[i] = 1'b1;
         end else begin
            shadow_d[i]  = shadow_q[i];
            pending_d[i] = pending_q[i];
         end
      end

      // Stopped: commit the cycle after capture. Running: only on a period
      // boundary. A start from stopped flushes anything captured alongside it
      // so the machine never runs on stale parameters.
      commit_s = ((|pending_q) & (~machine_on_q | period_boundary)) |
                 (start_eff_s & ~machine_on_q & (|pending_d));

      if (commit_s) begin
         for (int i = 0; i < 4; i++) begin
            if (pending_d[i]) begin
               // shadow_d already holds a value captured this very cycle.
               active_d[i] = shadow_d[i];
            end else begin
               active_d[i] = active_q[i];
            end
         end
         pending_d      = 4'b0000;
         param_update_d = 1'b1;
      end else begin
         active_d       = active_q;
         param_update_d = 1'b0;
      end
   end

   // Feedback timer, status word latch and stretched feedback ack.
   always_comb begin
      timer_d   = timer_q;
      hold_d    = hold_q;
      fb_ack_d  = fb_ack_q;
      fb_data_d = fb_data_q;
      wrap_s    = (timer_q == TMR_LAST);

      if (wrap_s) begin
         timer_d   = {TMR_W{1'b0}};
         fb_data_d = {machine_on_q, err_q[TON], err_q[TOFF], err_q[IP], err_q[WAVE],
                      3'b000, pulse_cnt_q};
         fb_ack_d  = 1'b1;
         hold_d    = HOLD_RLD;
      end else begin
         timer_d   = timer_q + TMR_W'(1);
         fb_data_d = fb_data_q;
         if (hold_q != {HOLD_W{1'b0}}) begin
            hold_d   = hold_q - HOLD_W'(1);
            fb_ack_d = 1'b1;
         end else begin
            hold_d   = hold_q;
            fb_ack_d = 1'b0;
         end
      end
   end

   // State registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q        <= 6'b000000;
         sync2_q        <= 6'b000000;
         sync3_q        <= 6'b000000;
         shadow_q       <= PARAM_RST;
         active_q       <= PARAM_RST;
         pending_q      <= 4'b0000;
         err_q          <= 4'b0000;
         param_update_q <= 1'b0;
         machine_on_q   <= 1'b0;
         pulse_cnt_q    <= 24'h00_0000;
         timer_q        <= {TMR_W{1'b0}};
         hold_q         <= {HOLD_W{1'b0}};
         fb_ack_q       <= 1'b0;
         fb_data_q      <= 32'h0000_0000;
      end else begin
         sync1_q        <= sync1_d;
         sync2_q        <= sync2_d;
         sync3_q        <= sync3_d;
         shadow_q       <= shadow_d;
         active_q       <= active_d;
         pending_q      <= pending_d;
         err_q          <= err_d;
         param_update_q <= param_update_d;
         machine_on_q   <= machine_on_d;
         pulse_cnt_q    <= pulse_cnt_d;
         timer_q        <= timer_d;
         hold_q         <= hold_d;
         fb_ack_q       <= fb_ack_d;
         fb_data_q      <= fb_data_d;
      end
   end

   assign machine_on              = machine_on_q;
   assign ton_active              = active_q[TON];
   assign toff_active             = active_q[TOFF];
   assign ip_active               = active_q[IP];
   assign waveform_active         = active_q[WAVE];
   assign param_update            = param_update_q;
   assign dec.feedback_data_async = fb_data_q;
   assign dec.change_feedback_ack = fb_ack_q;

endmodule

// File: tb/tb_pulse_param_sync.sv
// tb_pulse_param_sync
// Directed scenarios followed by randomised operations, checked against a
// transaction-level model of the committed parameter set and status word.
module tb_pulse_param_sync;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        period_boundary;
   logic        machine_on;
   logic [15:0] ton_active, toff_active, ip_active, waveform_active;
   logic        param_update;

   pulse_param_sync_if bus ();

   pulse_param_sync dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .dec             (bus),
      .period_boundary (period_boundary),
      .machine_on      (machine_on),
      .ton_active      (ton_active),
      .toff_active     (toff_active),
      .ip_active       (ip_active),
      .waveform_active (waveform_active),
      .param_update    (param_update)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   int upd_seen = 0;

   // Reference model: committed set, pending shadows, flags, counter.
   bit      exp_on;
   int      exp_act [4];
   int      exp_sh  [4];
   bit      exp_pend[4];
   bit      exp_err [4];
   int      exp_cnt;
   int      exp_upd;

   // Count param_update pulses, sampled mid-cycle.
   always @(negedge clk) begin
      if (rst_n && param_update) upd_seen <= upd_seen + 1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   function automatic void mdl_reset();
      exp_on = 1'b0;
      exp_act = '{80, 20, 30, 0};
      exp_sh  = '{80, 20, 30, 0};
      for (int i = 0; i < 4; i++) begin
         exp_pend[i] = 1'b0;
         exp_err[i]  = 1'b0;
      end
      exp_cnt = 0;
      exp_upd = upd_seen;
   endfunction

   function automatic void mdl_commit();
      bit any = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (exp_pend[i]) begin
            exp_act[i]  = exp_sh[i];
            exp_pend[i] = 1'b0;
            any = 1'b1;
         end
      end
      if (any) exp_upd++;
   endfunction

   function automatic void mdl_write(input int idx, input int val);
      int lo, hi, v;
      if (idx == 3) begin
         if (val >= 4) exp_err[3] = 1'b1;
         else begin
            exp_sh[3] = val; exp_pend[3] = 1'b1;
         end
      end else begin
         lo = 1;
         hi = (idx == 2) ? 100 : 1000;
         v  = val;
         if (v < lo) begin v = lo; exp_err[idx] = 1'b1; end
         else if (v > hi) begin v = hi; exp_err[idx] = 1'b1; end
         exp_sh[idx] = v; exp_pend[idx] = 1'b1;
      end
      if (!exp_on) mdl_commit();
   endfunction

   function automatic logic [31:0] mdl_status();
      return {exp_on, exp_err[0], exp_err[1], exp_err[2], exp_err[3], 3'b000, exp_cnt[23:0]};
   endfunction

   task automatic set_ack(input int idx, input logic v);
      case (idx)
         0: bus.change_Ton_ack      = v;
         1: bus.change_Toff_ack     = v;
         2: bus.change_Ip_ack       = v;
         3: bus.change_waveform_ack = v;
         4: bus.machine_start_ack   = v;
         default: bus.machine_stop_ack = v;
      endcase
   endtask

   task automatic write_param(input int idx, input int val);
      case (idx)
         0: bus.Ton_data_async      = 16'(val);
         1: bus.Toff_data_async     = 16'(val);
         2: bus.Ip_data_async       = 16'(val);
         default: bus.waveform_data_async = 16'(val);
      endcase
      set_ack(idx, 1'b1);
      tick($urandom_range(1, 10));
      set_ack(idx, 1'b0);
      tick(10);
      mdl_write(idx, val);
   endtask

   task automatic do_start();
      set_ack(4, 1'b1); tick($urandom_range(1, 8)); set_ack(4, 1'b0); tick(10);
      if (!exp_on) mdl_commit();
      exp_on = 1'b1;
      exp_cnt = 0;
      for (int i = 0; i < 4; i++) exp_err[i] = 1'b0;
   endtask

   task automatic do_stop();
      set_ack(5, 1'b1); tick($urandom_range(1, 8)); set_ack(5, 1'b0); tick(10);
      exp_on = 1'b0;
      mdl_commit();
   endtask

   task automatic do_start_stop();
      set_ack(4, 1'b1); set_ack(5, 1'b1); tick(5);
      set_ack(4, 1'b0); set_ack(5, 1'b0); tick(10);
      exp_on = 1'b0;
      mdl_commit();
   endtask

   task automatic do_boundary();
      period_boundary = 1'b1; tick(1); period_boundary = 1'b0; tick(3);
      if (exp_on) begin
         mdl_commit();
         if (exp_cnt < 24'hFF_FFFF) exp_cnt++;
      end
   endtask

   task automatic check_state(input string tag);
      chk({tag, "_on"},   32'(machine_on),      32'(exp_on));
      chk({tag, "_ton"},  32'(ton_active),      32'(exp_act[0]));
      chk({tag, "_toff"}, 32'(toff_active),     32'(exp_act[1]));
      chk({tag, "_ip"},   32'(ip_active),       32'(exp_act[2]));
      chk({tag, "_wave"}, 32'(waveform_active), 32'(exp_act[3]));
      chk({tag, "_upd"},  32'(upd_seen),        32'(exp_upd));
   endtask

   task automatic wait_feedback(input string tag);
      int c = 0;
      int w = 0;
      logic [31:0] data;
      while (bus.change_feedback_ack && c < 20) begin tick(1); c++; end
      c = 0;
      while (!bus.change_feedback_ack && c < 1100) begin tick(1); c++; end
      chk({tag, "_fb_seen"}, 32'(c < 1100), 32'd1);
      data = bus.feedback_data_async;
      chk({tag, "_fb_data"}, data, mdl_status());
      while (bus.change_feedback_ack && w < 20) begin
         tick(1); w++;
         if (bus.change_feedback_ack) chk({tag, "_fb_stable"}, bus.feedback_data_async, data);
      end
      chk({tag, "_fb_width"}, 32'(w), 32'd4);
   endtask

   initial begin
      int c;
      int op;
      int base;
      rst_n = 1'b0;
      period_boundary = 1'b0;
      bus.machine_start_ack = 1'b0;   bus.machine_stop_ack = 1'b0;
      bus.change_Ton_ack = 1'b0;      bus.change_Toff_ack = 1'b0;
      bus.change_Ip_ack = 1'b0;       bus.change_waveform_ack = 1'b0;
      bus.Ton_data_async = 16'd0;     bus.Toff_data_async = 16'd0;
      bus.Ip_data_async = 16'd0;      bus.waveform_data_async = 16'd0;
      mdl_reset();
      tick(3);
      check_state("rst");
      chk("rst_fb", bus.feedback_data_async, 32'h0);
      rst_n = 1'b1;

      // First feedback publication lands exactly FEEDBACK_PERIOD cycles after reset.
      c = 0;
      while (c < 1100) begin
         tick(1); c++;
         if (bus.change_feedback_ack) break;
      end
      chk("first_fb_cycle", 32'(c), 32'd1000);
      chk("first_fb_data", bus.feedback_data_async, 32'h0);
      c = 0;
      while (bus.change_feedback_ack && c < 20) begin tick(1); c++; end
      chk("first_fb_width", 32'(c), 32'd4);

      // Stopped update with a wide ack: one commit within 5 clocks.
      bus.Ton_data_async = 16'd150;
      bus.change_Ton_ack = 1'b1;
      c = 0;
      while (ton_active != 16'd150 && c < 20) begin tick(1); c++; end
      chk("ton_latency_le5", 32'(c >= 3 && c <= 5), 32'd1);
      if (c < 9) tick(9 - c);
      bus.change_Ton_ack = 1'b0;
      tick(10);
      mdl_write(0, 150);
      check_state("off_upd");

      // Running: updates wait for a boundary, then commit together.
      do_start();
      write_param(1, 50);
      write_param(2, 40);
      tick(200);
      check_state("run_hold");
      chk("run_hold_toff", 32'(toff_active), 32'd20);
      period_boundary = 1'b1; tick(1); period_boundary = 1'b0;
      chk("pb_toff", 32'(toff_active), 32'd50);
      chk("pb_ip", 32'(ip_active), 32'd40);
      tick(3);
      mdl_commit();
      exp_cnt++;
      check_state("run_commit");

      // Out-of-range words clamp and set the sticky error flags.
      write_param(0, 0);
      write_param(1, 2000);
      write_param(2, 500);
      write_param(3, 7);
      do_boundary();
      check_state("clamp");
      chk("clamp_ton", 32'(ton_active), 32'd1);
      wait_feedback("clamp");
      do_start();
      wait_feedback("err_clr");

      // Start and stop together: stop wins. Then count five periods.
      do_stop();
      do_start_stop();
      check_state("start_stop");
      do_start();
      repeat (5) do_boundary();
      wait_feedback("cnt5");

      // Randomised mix of operations.
      for (int n = 0; n < 40; n++) begin
         op = $urandom_range(0, 9);
         case (op)
            0, 1: write_param($urandom_range(0, 1), $urandom_range(0, 1100));
            2:    write_param(2, $urandom_range(0, 120));
            3, 4: write_param(3, $urandom_range(0, 6));
            5, 6: do_boundary();
            7:    do_start();
            8:    do_stop();
            default: do_start_stop();
         endcase
         check_state("rnd");
         if ((n % 10) == 9) wait_feedback("rnd");
      end

      // Reset while running with a Ton update pending.
      if (!exp_on) do_start();
      write_param(0, 300);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_on", 32'(machine_on), 32'd0);
      chk("mid_rst_ton", 32'(ton_active), 32'd80);
      chk("mid_rst_toff", 32'(toff_active), 32'd20);
      chk("mid_rst_ip", 32'(ip_active), 32'd30);
      chk("mid_rst_wave", 32'(waveform_active), 32'd0);
      chk("mid_rst_upd", 32'(param_update), 32'd0);
      chk("mid_rst_fb", bus.feedback_data_async, 32'h0);
      chk("mid_rst_fback", 32'(bus.change_feedback_ack), 32'd0);
      tick(2);
      rst_n = 1'b1;
      mdl_reset();
      base = upd_seen;
      tick(30);
      chk("post_rst_no_upd", 32'(upd_seen), 32'(base));
      check_state("post_rst");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
